// File: rtl/alu_pipe.sv
// alu_pipe: registered Hack-style ALU with carry/overflow flags and a
// multi-cycle unsigned shift-add multiply. Operands arrive on a valid/ready
// input handshake; the result is held until consumed on the output side.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid / in_ready     operand beat handshake (in_ready is combinational)
//   x, y [WIDTH]            operands
//   zx nx zy ny f no        Hack control bits
//   mul                     multiply select (overrides f)
//   out_valid / out_ready   result handshake
//   o [WIDTH], zr, ng       result, zero, negative
//   cy, ov                  carry / high-product nonzero, signed add overflow
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

  state_t r_state, w_state_nxt;

  logic [WIDTH-1:0]   w_x, w_y, w_r, w_o;
  logic [WIDTH:0]     w_sum;
  logic               w_take, w_mul_done;
  logic [2*WIDTH-1:0] w_acc_nxt;

  logic [2*WIDTH-1:0] r_mx;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]   r_my;   // multiplier, consumed LSB-first
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_no;   // output invert captured with the mul beat

  // operand preprocessing
  always_comb begin
    w_x = zx ? '0 : x;
    w_x = nx ? ~w_x : w_x;
    w_y = zy ? '0 : y;
    w_y = ny ? ~w_y : w_y;
  end

  assign w_sum      = {1'b0, w_x} + {1'b0, w_y};
  assign w_r        = f ? w_sum[WIDTH-1:0] : (w_x & w_y);
  assign w_o        = no ? ~w_r : w_r;

  assign in_ready   = (r_state == S_IDLE) || (r_state == S_HOLD && out_ready);
  assign out_valid  = (r_state == S_HOLD);
  assign w_take     = in_valid && in_ready;

  assign w_acc_nxt  = r_my[0] ? (r_acc + r_mx) : r_acc;
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_HOLD: begin
        if (w_take)                          w_state_nxt = mul ? S_MUL : S_HOLD;
        else if (r_state == S_HOLD && out_ready) w_state_nxt = S_IDLE;
      end
      S_MUL:   if (w_mul_done) w_state_nxt = S_HOLD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // multiply datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mx  <= '0;
      r_my  <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_no  <= 1'b0;
    end else if (w_take && mul) begin
      r_mx  <= {{WIDTH{1'b0}}, w_x};
      r_my  <= w_y;
      r_acc <= '0;
      r_cnt <= '0;
      r_no  <= no;
    end else if (r_state == S_MUL) begin
      r_acc <= w_acc_nxt;
      r_mx  <= r_mx << 1;
      r_my  <= r_my >> 1;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // result and flag registers; untouched while a result waits in HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o  <= '0;
      zr <= 1'b0;
      ng <= 1'b0;
      cy <= 1'b0;
      ov <= 1'b0;
    end else if (w_take && !mul) begin
      o  <= w_o;
      zr <= (w_o == '0);
      ng <= w_o[WIDTH-1];
      cy <= f & w_sum[WIDTH];
      ov <= f & (w_x[WIDTH-1] == w_y[WIDTH-1]) & (w_sum[WIDTH-1] != w_x[WIDTH-1]);
    end else if (w_mul_done) begin
      o  <= r_no ? ~w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
      zr <= ((r_no ? ~w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0]) == '0);
      ng <= r_no ? ~w_acc_nxt[WIDTH-1] : w_acc_nxt[WIDTH-1];
      cy <= |w_acc_nxt[2*WIDTH-1:WIDTH];
      ov <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=16.
module tb_alu_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] x, y;
  logic        zx, nx, zy, ny, f, no, mul;
  logic        out_valid, out_ready;
  logic [15:0] o;
  logic        zr, ng, cy, ov;

  int n_chk = 0;
  int n_fail = 0;

  alu_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .mul(mul),
    .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .zr(zr), .ng(ng), .cy(cy), .ov(ov)
  );

  always #5 clk = ~clk;

  // ctl = {zx,nx,zy,ny,f,no}
  task automatic drive(input logic [15:0] xa, input logic [15:0] ya,
                       input logic [5:0] ctl, input logic m);
    x = xa; y = ya;
    {zx, nx, zy, ny, f, no} = ctl;
    mul = m;
    in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({out_valid, o, zr, ng, cy, ov, in_ready} !== {1'b0, 16'h0, 4'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: got ov=%b o=%h zr=%b ng=%b cy=%b ovf=%b rdy=%b, want 0/0000/0/0/0/0/1",
               out_valid, o, zr, ng, cy, ov, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    drive(16'h0005, 16'h0003, 6'b000010, 1'b0);
    tick(); in_valid = 1'b0;
    n_chk++;
    if ({out_valid, o, zr, ng, cy, ov} !== {1'b1, 16'h0008, 4'b0000}) begin
      n_fail++;
      $display("FAIL add: got v=%b o=%h zr=%b ng=%b cy=%b ov=%b, want 1 0008 0 0 0 0",
               out_valid, o, zr, ng, cy, ov);
    end
    drain();
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL add_drain: got v=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_overflow();
    drive(16'h7FFF, 16'h0001, 6'b000010, 1'b0);
    tick(); in_valid = 1'b0;
    n_chk++;
    if ({o, zr, ng, cy, ov} !== {16'h8000, 4'b0101}) begin
      n_fail++;
      $display("FAIL ovf_pos: got o=%h zr=%b ng=%b cy=%b ov=%b, want 8000 0 1 0 1", o, zr, ng, cy, ov);
    end
    drain();
    drive(16'hFFFF, 16'h0001, 6'b000010, 1'b0);
    tick(); in_valid = 1'b0;
    n_chk++;
    if ({o, zr, ng, cy, ov} !== {16'h0000, 4'b1010}) begin
      n_fail++;
      $display("FAIL carry: got o=%h zr=%b ng=%b cy=%b ov=%b, want 0000 1 0 1 0", o, zr, ng, cy, ov);
    end
    drain();
  endtask

  task automatic test_constants();
    logic [5:0]  ctl [3] = '{6'b101010, 6'b111111, 6'b111010};
    logic [15:0] exp_o [3] = '{16'h0000, 16'h0001, 16'hFFFF};
    logic [3:0]  exp_f [3] = '{4'b1000, 4'b0010, 4'b0100};  // zr ng cy ov
    for (int i = 0; i < 3; i++) begin
      drive(16'h1234, 16'h5678, ctl[i], 1'b0);
      tick(); in_valid = 1'b0;
      n_chk++;
      if ({o, zr, ng, cy, ov} !== {exp_o[i], exp_f[i]}) begin
        n_fail++;
        $display("FAIL const%0d: got o=%h flags=%b%b%b%b, want %h %b", i, o, zr, ng, cy, ov, exp_o[i], exp_f[i]);
      end
      drain();
    end
  endtask

  task automatic test_multiply();
    logic [15:0] xs [2] = '{16'h0100, 16'h0007};
    logic [15:0] ys [2] = '{16'h0100, 16'h0006};
    logic [15:0] eo [2] = '{16'h0000, 16'h002A};
    logic        ez [2] = '{1'b1, 1'b0};
    logic        ec [2] = '{1'b1, 1'b0};
    int lat, busy_bad;
    for (int i = 0; i < 2; i++) begin
      drive(xs[i], ys[i], 6'b000000, 1'b1);
      tick();
      // garbage on the inputs while busy must not be taken or used
      drive(16'hDEAD, 16'hBEEF, 6'b000010, 1'b0);
      lat = 0; busy_bad = 0;
      while (!out_valid && lat < 40) begin
        if (in_ready !== 1'b0) busy_bad++;
        tick(); lat++;
      end
      in_valid = 1'b0;
      n_chk++;
      if (lat != 16 || busy_bad != 0) begin
        n_fail++;
        $display("FAIL mul%0d_latency: got %0d cycles, %0d ready-while-busy, want 16, 0", i, lat, busy_bad);
      end
      n_chk++;
      if ({o, zr, cy, ov} !== {eo[i], ez[i], ec[i], 1'b0}) begin
        n_fail++;
        $display("FAIL mul%0d_result: got o=%h zr=%b cy=%b ov=%b, want %h %b %b 0",
                 i, o, zr, cy, ov, eo[i], ez[i], ec[i]);
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    drive(16'h0001, 16'h0002, 6'b000010, 1'b0);
    tick();
    drive(16'h0100, 16'h0200, 6'b000010, 1'b0);  // pending beat must wait
    for (int i = 0; i < 5; i++) begin
      if (o !== 16'h0003 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      tick();
    end
    in_valid = 1'b0;
    n_chk++;
    if (bad != 0 || o !== 16'h0003) begin
      n_fail++;
      $display("FAIL backpressure: %0d unstable cycles, o=%h, want 0 and 0003", bad, o);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] xs [4] = '{16'h000A, 16'hF0F0, 16'h1234, 16'h00FF};
    logic [15:0] ys [4] = '{16'h0001, 16'hFF00, 16'h1111, 16'h0F0F};
    logic [5:0]  cs [4] = '{6'b000010, 6'b000000, 6'b000010, 6'b000001};
    logic [15:0] eo [4] = '{16'h000B, 16'hF000, 16'h2345, 16'hFFF0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(xs[i], ys[i], cs[i], 1'b0);
      #1;
      n_chk++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b%0d_ready: got %b, want 1", i, in_ready);
      end
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || o !== eo[i]) begin
        n_fail++;
        $display("FAIL b2b%0d: got v=%b o=%h, want 1 %h", i, out_valid, o, eo[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_empty: got v=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    drive(16'h0003, 16'h0005, 6'b000000, 1'b1);
    tick(); in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, o, zr, ng, cy, ov, in_ready} !== {1'b0, 16'h0, 4'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_mul: got v=%b o=%h flags=%b%b%b%b rdy=%b, want 0 0000 0000 1",
               out_valid, o, zr, ng, cy, ov, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    drive(16'h0002, 16'h0002, 6'b000010, 1'b0);
    tick(); in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1 || o !== 16'h0004) begin
      n_fail++;
      $display("FAIL post_reset_add: got v=%b o=%h, want 1 0004", out_valid, o);
    end
    drain();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; {zx, nx, zy, ny, f, no, mul} = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_add();
    test_overflow();
    test_constants();
    test_multiply();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
